// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port ids,
// default address width and the address legality check.
package dm_arb_pkg;

  localparam int ADDR_W_DEF = 12;

  // Port ids; also the value held in the last-served pointer
  localparam logic P_DP = 1'b0;  // integer datapath load/store unit
  localparam logic P_IO = 1'b1;  // I/O or debug master

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // An address is rejected if it is not word aligned or lies above the array
  function automatic logic addr_bad(input logic [31:0] a, input int aw);
    return (a[1:0] != 2'b00) || ((a >> aw) != 32'd0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. A lone requester always wins;
// on a tie the port that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_vld_o,
  output logic       gnt_id_o
);

  // Pick the winner from the request pair and the last-served pointer
  always_comb begin
    gnt_vld_o = |req_i;
    if (&req_i) gnt_id_o = ~last_i;
    else        gnt_id_o = req_i[1];
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and single-word access sequencer for the
// data memory. Each grant becomes IDLE -> ACCESS -> DONE (or IDLE -> DONE
// for a rejected address), ending in a one-cycle ack to the winner.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic        busy
);

  state_e             state_q;
  logic               last_q;
  logic               win_q;
  logic               wr_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               err_q;
  logic [1:0]         ack_q;
  logic [1:0][31:0]   rdata_q;

  // Port inputs gathered into arrays indexed by port id
  logic [1:0]         req;
  logic [1:0]         wr_in;
  logic [1:0][31:0]   addr_in;
  logic [1:0][31:0]   wdata_in;
  logic               gnt_vld;
  logic               gnt_id;

  assign req      = {p1_req, p0_req};
  assign wr_in    = {p1_wr, p0_wr};
  assign addr_in  = {p1_addr, p0_addr};
  assign wdata_in = {p1_wdata, p0_wdata};

  rr_arb2 u_pick (
    .req_i     (req),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  // Sequencer: latch the winner in IDLE, run one memory cycle, then ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= P_IO;   // port 0 wins the first tie
      win_q   <= P_DP;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            win_q   <= gnt_id;
            last_q  <= gnt_id;
            wr_q    <= wr_in[gnt_id];
            addr_q  <= addr_in[gnt_id];
            wdata_q <= wdata_in[gnt_id];
            if (addr_bad(addr_in[gnt_id], ADDR_W)) begin
              // Rejected: skip the memory cycle entirely
              err_q          <= 1'b1;
              ack_q[gnt_id]  <= 1'b1;
              state_q        <= DONE;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!wr_q) rdata_q[win_q] <= dm_dout;
          ack_q[win_q] <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory pins are driven only in ACCESS, straight from state so that an
  // asynchronous reset drops the strobes before the next edge
  always_comb begin
    dm_cs   = 1'b0;
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    dm_addr = '0;
    dm_din  = '0;
    if (state_q == ACCESS) begin
      dm_cs   = 1'b1;
      dm_rd   = ~wr_q;
      dm_wr   = wr_q;
      dm_addr = addr_q;
      dm_din  = wdata_q;
    end
  end

  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p0_err   = ack_q[0] & err_q;
  assign p1_err   = ack_q[1] & err_q;
  assign p0_rdata = rdata_q[0];
  assign p1_rdata = rdata_q[1];
  assign busy     = (state_q != IDLE);

endmodule
